// File: rtl/coherence_bus_rr_if.sv
// Bundle of every L1-side and L2-side signal of the snooping coherence bus.
// The master modport is the bus itself; slave is the L1/L2 environment.
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

interface coherence_bus_rr_if #(
    parameter int NUM_CORES      = 4,
    parameter int LINE_ADDR_BITS = `ADDR_BITS - `OFFSET_BITS,
    parameter int LINE_BITS      = `CACHELINE_BITS
);
    logic [NUM_CORES-1:0]                l1_req_valid;
    logic [NUM_CORES-1:0]                l1_req_ready;
    logic [NUM_CORES*LINE_ADDR_BITS-1:0] l1_req_addr;
    logic [NUM_CORES-1:0][1:0]           l1_req;
    logic [NUM_CORES*LINE_BITS-1:0]      l1_req_data;
    logic [NUM_CORES-1:0]                l1_resp_valid;
    logic [LINE_BITS-1:0]                l1_resp_data;
    logic                                l1_resp_shared;
    logic [NUM_CORES-1:0]                l1_snoop_valid;
    logic [LINE_ADDR_BITS-1:0]           l1_snoop_addr;
    logic [1:0]                          l1_snoop_req;
    logic [NUM_CORES-1:0]                l1_snoop_shared;
    logic [NUM_CORES-1:0]                l1_snoop_dirty;
    logic [NUM_CORES*LINE_BITS-1:0]      l1_snoop_data;
    logic                                l2_req_valid;
    logic                                l2_req_ready;
    logic [LINE_ADDR_BITS-1:0]           l2_req_addr;
    logic                                l2_req_rw;
    logic [LINE_BITS-1:0]                l2_req_data;
    logic                                l2_resp_valid;
    logic [LINE_BITS-1:0]                l2_resp_data;

    modport master (
        input  l1_req_valid, l1_req_addr, l1_req, l1_req_data,
        input  l1_snoop_shared, l1_snoop_dirty, l1_snoop_data,
        input  l2_req_ready, l2_resp_valid, l2_resp_data,
        output l1_req_ready, l1_resp_valid, l1_resp_data, l1_resp_shared,
        output l1_snoop_valid, l1_snoop_addr, l1_snoop_req,
        output l2_req_valid, l2_req_addr, l2_req_rw, l2_req_data
    );

    modport slave (
        output l1_req_valid, l1_req_addr, l1_req, l1_req_data,
        output l1_snoop_shared, l1_snoop_dirty, l1_snoop_data,
        output l2_req_ready, l2_resp_valid, l2_resp_data,
        input  l1_req_ready, l1_resp_valid, l1_resp_data, l1_resp_shared,
        input  l1_snoop_valid, l1_snoop_addr, l1_snoop_req,
        input  l2_req_valid, l2_req_addr, l2_req_rw, l2_req_data
    );
endinterface

// File: rtl/coherence_bus_rr.sv
// Snooping coherence bus: round-robin arbitration among L1 controllers, one
// transaction at a time, cache-to-cache supply with dirty flush, L2 fallback.
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

module coherence_bus_rr #(
    parameter int NUM_CORES      = 4,
    parameter int LINE_ADDR_BITS = `ADDR_BITS - `OFFSET_BITS,
    parameter int LINE_BITS      = `CACHELINE_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    coherence_bus_rr_if.master   bus
);
    localparam int CPU_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2,
        BUS_WB   = 2'd3
    } bus_req_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SNOOP   = 3'd1,
        S_SRESP   = 3'd2,
        S_FLUSH   = 3'd3,
        S_L2_REQ  = 3'd4,
        S_L2_WAIT = 3'd5,
        S_RESP    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t                    state_q;
    logic [CPU_W-1:0]          rr_ptr_q;
    logic [CPU_W-1:0]          cpu_q;
    bus_req_t                  req_q;
    logic [LINE_ADDR_BITS-1:0] addr_q;
    logic [LINE_BITS-1:0]      data_q;
    logic                      shared_q;
    logic                      rw_q;

    logic                      grant_found_s;
    logic [CPU_W-1:0]          grant_idx_s;
    logic [NUM_CORES-1:0]      grant_onehot_s;
    logic [NUM_CORES-1:0]      req_mask_s;
    logic                      src_found_s;
    logic                      src_dirty_s;
    logic [CPU_W-1:0]          src_idx_s;
    logic                      sharers_s;

    // Round-robin scan starting just after the last winner.
    always_comb begin
        logic [CPU_W-1:0] idx;
        logic             hit;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            idx           = CPU_W'((int'(rr_ptr_q) + i) % NUM_CORES);
            hit           = !grant_found_s && bus.l1_req_valid[idx];
            grant_idx_s   = hit ? idx : grant_idx_s;
            grant_found_s = grant_found_s | hit;
        end
    end

    // One-hot decodes of the arbitration winner and of the latched requester.
    always_comb begin
        grant_onehot_s              = '0;
        grant_onehot_s[grant_idx_s] = 1'b1;
        req_mask_s                  = '0;
        req_mask_s[cpu_q]           = 1'b1;
    end

    // Data-source pick: lowest dirty peer wins over any lower clean sharer.
    always_comb begin
        logic hit;
        src_found_s = 1'b0;
        src_dirty_s = 1'b0;
        src_idx_s   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            hit         = !src_found_s && (CPU_W'(i) != cpu_q) && bus.l1_snoop_dirty[CPU_W'(i)];
            src_idx_s   = hit ? CPU_W'(i) : src_idx_s;
            src_dirty_s = src_dirty_s | hit;
            src_found_s = src_found_s | hit;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            hit         = !src_found_s && (CPU_W'(i) != cpu_q) && bus.l1_snoop_shared[CPU_W'(i)];
            src_idx_s   = hit ? CPU_W'(i) : src_idx_s;
            src_found_s = src_found_s | hit;
        end
    end

    assign sharers_s = |(bus.l1_snoop_shared & ~req_mask_s);

    // Transaction FSM with all per-transaction registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= CPU_W'(NUM_CORES - 1);
            cpu_q    <= '0;
            req_q    <= BUS_RD;
            addr_q   <= '0;
            data_q   <= '0;
            shared_q <= 1'b0;
            rw_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_found_s) begin
                        rr_ptr_q <= grant_idx_s;
                        cpu_q    <= grant_idx_s;
                        req_q    <= bus_req_t'(bus.l1_req[grant_idx_s]);
                        addr_q   <= bus.l1_req_addr[grant_idx_s*LINE_ADDR_BITS +: LINE_ADDR_BITS];
                        data_q   <= bus.l1_req_data[grant_idx_s*LINE_BITS +: LINE_BITS];
                        shared_q <= 1'b0;
                        rw_q     <= 1'b0;
                        state_q  <= S_SNOOP;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_SNOOP: begin
                    case (req_q)
                        BUS_UPGR: state_q <= S_DONE;
                        BUS_WB: begin
                            rw_q    <= 1'b1;
                            state_q <= S_L2_REQ;
                        end
                        default:  state_q <= S_SRESP;
                    endcase
                end
                S_SRESP: begin
                    // Peers invalidate on RDX, so the requester never keeps a shared copy.
                    shared_q <= (req_q == BUS_RDX) ? 1'b0 : sharers_s;
                    if (src_found_s) begin
                        data_q  <= bus.l1_snoop_data[src_idx_s*LINE_BITS +: LINE_BITS];
                        state_q <= (src_dirty_s && req_q == BUS_RD) ? S_FLUSH : S_RESP;
                    end else begin
                        rw_q    <= 1'b0;
                        state_q <= S_L2_REQ;
                    end
                end
                S_FLUSH: begin
                    state_q <= bus.l2_req_ready ? S_RESP : S_FLUSH;
                end
                S_L2_REQ: begin
                    if (bus.l2_req_ready) begin
                        state_q <= rw_q ? S_DONE : S_L2_WAIT;
                    end else begin
                        state_q <= S_L2_REQ;
                    end
                end
                S_L2_WAIT: begin
                    if (bus.l2_resp_valid) begin
                        data_q  <= bus.l2_resp_data;
                        state_q <= S_RESP;
                    end else begin
                        state_q <= S_L2_WAIT;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Ready is the only input-dependent output; it is forced low during reset.
    assign bus.l1_req_ready   = (reset_n && state_q == S_IDLE && grant_found_s) ? grant_onehot_s : '0;
    assign bus.l1_resp_valid  = (state_q == S_RESP || state_q == S_DONE) ? req_mask_s : '0;
    assign bus.l1_resp_data   = (state_q == S_RESP) ? data_q : '0;
    assign bus.l1_resp_shared = (state_q == S_RESP) && shared_q;
    assign bus.l1_snoop_valid = (state_q == S_SNOOP) ? ~req_mask_s : '0;
    assign bus.l1_snoop_addr  = addr_q;
    assign bus.l1_snoop_req   = req_q;
    assign bus.l2_req_valid   = (state_q == S_FLUSH) || (state_q == S_L2_REQ);
    assign bus.l2_req_rw      = (state_q == S_FLUSH) || (state_q == S_L2_REQ && rw_q);
    assign bus.l2_req_addr    = bus.l2_req_valid ? addr_q : '0;
    assign bus.l2_req_data    = bus.l2_req_rw ? data_q : '0;

endmodule

// File: tb/tb_coherence_bus_rr.sv
// Directed self-checking bench for coherence_bus_rr (4 cores, 64-bit lines).
module tb_coherence_bus_rr;
    localparam int NC = 4;
    localparam int LA = 26;
    localparam int LB = 64;
    localparam logic [1:0] RD = 2'd0, RDX = 2'd1, UPGR = 2'd2, WB = 2'd3;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    coherence_bus_rr_if #(.NUM_CORES(NC), .LINE_ADDR_BITS(LA), .LINE_BITS(LB)) bus_if ();

    coherence_bus_rr #(.NUM_CORES(NC), .LINE_ADDR_BITS(LA), .LINE_BITS(LB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.l1_req_valid    = '0;
        bus_if.l1_req_addr     = '0;
        bus_if.l1_req          = '0;
        bus_if.l1_req_data     = '0;
        bus_if.l1_snoop_shared = '0;
        bus_if.l1_snoop_dirty  = '0;
        bus_if.l1_snoop_data   = '0;
        bus_if.l2_req_ready    = 1'b0;
        bus_if.l2_resp_valid   = 1'b0;
        bus_if.l2_resp_data    = '0;
    endtask

    task automatic set_req(input int c, input logic [1:0] t, input logic [LA-1:0] a, input logic [LB-1:0] d);
        bus_if.l1_req_valid[c]        = 1'b1;
        bus_if.l1_req[c]              = t;
        bus_if.l1_req_addr[c*LA +: LA] = a;
        bus_if.l1_req_data[c*LB +: LB] = d;
    endtask

    task automatic set_snoop(input int c, input logic sh, input logic dt, input logic [LB-1:0] d);
        bus_if.l1_snoop_shared[c]        = sh;
        bus_if.l1_snoop_dirty[c]         = dt;
        bus_if.l1_snoop_data[c*LB +: LB] = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        bus_if.l1_req_valid[1] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        tests++; if (bus_if.l1_req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b exp 0000", bus_if.l1_req_ready); end
        tests++; if ({bus_if.l1_resp_valid, bus_if.l1_resp_shared, bus_if.l1_snoop_valid, bus_if.l2_req_valid, bus_if.l2_req_rw} !== 11'd0) begin
            fails++; $display("FAIL reset_ctrl: got %b exp 0", {bus_if.l1_resp_valid, bus_if.l1_resp_shared, bus_if.l1_snoop_valid, bus_if.l2_req_valid, bus_if.l2_req_rw}); end
        tests++; if ({bus_if.l1_resp_data, bus_if.l2_req_data, bus_if.l1_snoop_addr, bus_if.l2_req_addr, bus_if.l1_snoop_req} !== '0) begin
            fails++; $display("FAIL reset_data: resp %h l2d %h saddr %h l2a %h sreq %b exp all 0", bus_if.l1_resp_data, bus_if.l2_req_data,
                              bus_if.l1_snoop_addr, bus_if.l2_req_addr, bus_if.l1_snoop_req); end
        clear_inputs();
        reset_n = 1'b1;
    endtask

    task automatic test_two_rd();
        logic [LB-1:0] a5;
        logic [LB-1:0] x5a;
        a5  = {8{8'hA5}};
        x5a = {8{8'h5A}};
        step();
        set_req(0, RD, 26'h10, '0);
        set_req(2, RD, 26'h20, '0);
        #1;
        tests++; if (bus_if.l1_req_ready !== 4'b0001) begin fails++; $display("FAIL rd_grant0: got %b exp 0001", bus_if.l1_req_ready); end
        step();
        bus_if.l1_req_valid[0] = 1'b0;
        #1;
        tests++; if (bus_if.l1_req_ready !== 4'b0000) begin fails++; $display("FAIL rd_ready_pulse: got %b exp 0000", bus_if.l1_req_ready); end
        tests++; if (bus_if.l1_snoop_valid !== 4'b1110) begin fails++; $display("FAIL rd_snoop_valid: got %b exp 1110", bus_if.l1_snoop_valid); end
        step();
        step();
        #1;
        tests++; if ({bus_if.l2_req_valid, bus_if.l2_req_rw, bus_if.l2_req_addr} !== {1'b1, 1'b0, 26'h10}) begin
            fails++; $display("FAIL rd_l2_req: got v%b rw%b a%h exp v1 rw0 a10", bus_if.l2_req_valid, bus_if.l2_req_rw, bus_if.l2_req_addr); end
        bus_if.l2_req_ready = 1'b1;
        step();
        bus_if.l2_req_ready  = 1'b0;
        bus_if.l2_resp_valid = 1'b1;
        bus_if.l2_resp_data  = a5;
        step();
        bus_if.l2_resp_valid = 1'b0;
        #1;
        tests++; if ({bus_if.l1_resp_valid, bus_if.l1_resp_data, bus_if.l1_resp_shared} !== {4'b0001, a5, 1'b0}) begin
            fails++; $display("FAIL rd_resp0: got v%b d%h s%b exp v0001 d%h s0", bus_if.l1_resp_valid, bus_if.l1_resp_data, bus_if.l1_resp_shared, a5); end
        step();
        #1;
        tests++; if (bus_if.l1_req_ready !== 4'b0100) begin fails++; $display("FAIL rd_grant2: got %b exp 0100", bus_if.l1_req_ready); end
        step();
        bus_if.l1_req_valid[2] = 1'b0;
        step();
        step();
        #1;
        tests++; if (bus_if.l2_req_addr !== 26'h20) begin fails++; $display("FAIL rd_l2_addr2: got %h exp 20", bus_if.l2_req_addr); end
        bus_if.l2_req_ready = 1'b1;
        step();
        bus_if.l2_req_ready  = 1'b0;
        bus_if.l2_resp_valid = 1'b1;
        bus_if.l2_resp_data  = x5a;
        step();
        bus_if.l2_resp_valid = 1'b0;
        #1;
        tests++; if ({bus_if.l1_resp_valid, bus_if.l1_resp_data} !== {4'b0100, x5a}) begin
            fails++; $display("FAIL rd_resp2: got v%b d%h exp v0100 d%h", bus_if.l1_resp_valid, bus_if.l1_resp_data, x5a); end
        // Pointer now sits on core 2, so core 3 must beat core 1.
        step();
        set_req(1, UPGR, 26'h1, '0);
        set_req(3, UPGR, 26'h3, '0);
        #1;
        tests++; if (bus_if.l1_req_ready !== 4'b1000) begin fails++; $display("FAIL rr_ptr_after2: got %b exp 1000", bus_if.l1_req_ready); end
        step();
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_rr_all();
        logic [NC-1:0] exp;
        for (int c = 0; c < NC; c++) set_req(c, UPGR, LA'(c + 8), '0);
        #1;
        for (int k = 0; k < 5; k++) begin
            int n;
            n   = 0;
            exp = '0;
            exp[k % NC] = 1'b1;
            while (bus_if.l1_req_ready == '0 && n < 8) begin step(); #1; n++; end
            tests++; if (bus_if.l1_req_ready !== exp) begin fails++; $display("FAIL rr_order[%0d]: got %b exp %b", k, bus_if.l1_req_ready, exp); end
            step();
            #1;
            tests++; if (bus_if.l1_req_ready !== 4'b0000) begin fails++; $display("FAIL rr_pulse[%0d]: got %b exp 0000", k, bus_if.l1_req_ready); end
            step();
            #1;
            tests++; if (bus_if.l1_resp_valid !== exp) begin fails++; $display("FAIL upgr_ack[%0d]: got %b exp %b", k, bus_if.l1_resp_valid, exp); end
            step();
            #1;
        end
        clear_inputs();
    endtask

    task automatic test_dirty();
        logic [LB-1:0] dead;
        dead = {4{16'hDEAD}};
        step();
        set_req(1, RD, 26'h40, '0);
        #1;
        tests++; if (bus_if.l1_req_ready !== 4'b0010) begin fails++; $display("FAIL dirty_grant: got %b exp 0010", bus_if.l1_req_ready); end
        step();
        bus_if.l1_req_valid[1] = 1'b0;
        set_snoop(1, 1'b1, 1'b1, {8{8'hBA}});
        set_snoop(2, 1'b1, 1'b0, {4{16'h2222}});
        set_snoop(3, 1'b1, 1'b1, dead);
        #1;
        tests++; if ({bus_if.l1_snoop_valid, bus_if.l1_snoop_addr, bus_if.l1_snoop_req} !== {4'b1101, 26'h40, RD}) begin
            fails++; $display("FAIL dirty_snoop: got v%b a%h r%b exp v1101 a40 r00", bus_if.l1_snoop_valid, bus_if.l1_snoop_addr, bus_if.l1_snoop_req); end
        step();
        step();
        clear_inputs();
        #1;
        tests++; if ({bus_if.l2_req_valid, bus_if.l2_req_rw, bus_if.l2_req_addr, bus_if.l2_req_data} !== {1'b1, 1'b1, 26'h40, dead}) begin
            fails++; $display("FAIL dirty_flush: got v%b rw%b a%h d%h exp v1 rw1 a40 d%h", bus_if.l2_req_valid, bus_if.l2_req_rw,
                              bus_if.l2_req_addr, bus_if.l2_req_data, dead); end
        step();
        bus_if.l2_req_ready = 1'b1;
        #1;
        tests++; if ({bus_if.l2_req_valid, bus_if.l1_resp_valid} !== {1'b1, 4'b0000}) begin
            fails++; $display("FAIL dirty_flush_hold: got v%b resp%b exp v1 resp0000", bus_if.l2_req_valid, bus_if.l1_resp_valid); end
        step();
        bus_if.l2_req_ready = 1'b0;
        #1;
        tests++; if ({bus_if.l1_resp_valid, bus_if.l1_resp_data, bus_if.l1_resp_shared, bus_if.l2_req_valid} !== {4'b0010, dead, 1'b1, 1'b0}) begin
            fails++; $display("FAIL dirty_resp: got v%b d%h s%b l2v%b exp v0010 d%h s1 l2v0", bus_if.l1_resp_valid, bus_if.l1_resp_data,
                              bus_if.l1_resp_shared, bus_if.l2_req_valid, dead); end
        step();
        #1;
        tests++; if ({bus_if.l1_resp_valid, bus_if.l2_req_valid} !== 5'd0) begin
            fails++; $display("FAIL dirty_after: got resp%b l2v%b exp 0", bus_if.l1_resp_valid, bus_if.l2_req_valid); end
    endtask

    task automatic test_rdx();
        logic          l2_seen;
        logic [LB-1:0] c2;
        c2 = {8{8'h2C}};
        step();
        set_req(0, RDX, 26'h80, '0);
        #1;
        l2_seen = bus_if.l2_req_valid;
        tests++; if (bus_if.l1_req_ready !== 4'b0001) begin fails++; $display("FAIL rdx_grant: got %b exp 0001", bus_if.l1_req_ready); end
        step();
        bus_if.l1_req_valid[0] = 1'b0;
        set_snoop(0, 1'b1, 1'b0, {8{8'h00}});
        set_snoop(2, 1'b1, 1'b0, c2);
        #1;
        l2_seen = l2_seen | bus_if.l2_req_valid;
        tests++; if (bus_if.l1_snoop_req !== RDX) begin fails++; $display("FAIL rdx_snoop_req: got %b exp 01", bus_if.l1_snoop_req); end
        step();
        #1;
        l2_seen = l2_seen | bus_if.l2_req_valid;
        step();
        clear_inputs();
        #1;
        l2_seen = l2_seen | bus_if.l2_req_valid;
        tests++; if ({bus_if.l1_resp_valid, bus_if.l1_resp_data, bus_if.l1_resp_shared} !== {4'b0001, c2, 1'b0}) begin
            fails++; $display("FAIL rdx_resp: got v%b d%h s%b exp v0001 d%h s0", bus_if.l1_resp_valid, bus_if.l1_resp_data, bus_if.l1_resp_shared, c2); end
        tests++; if (l2_seen !== 1'b0) begin fails++; $display("FAIL rdx_no_l2: got %b exp 0", l2_seen); end
        step();
    endtask

    task automatic test_wb();
        int            cnt;
        logic [LB-1:0] d7;
        d7 = {16{4'h7}};
        step();
        set_req(2, WB, 26'h33, d7);
        #1;
        tests++; if (bus_if.l1_req_ready !== 4'b0100) begin fails++; $display("FAIL wb_grant: got %b exp 0100", bus_if.l1_req_ready); end
        step();
        bus_if.l1_req_valid[2] = 1'b0;
        step();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus_if.l2_req_valid && bus_if.l2_req_rw && bus_if.l2_req_data == d7 && bus_if.l2_req_addr == 26'h33) cnt++;
            if (i == 5) bus_if.l2_req_ready = 1'b1;
            step();
        end
        bus_if.l2_req_ready = 1'b0;
        #1;
        tests++; if (cnt !== 6) begin fails++; $display("FAIL wb_l2_hold: got %0d cycles exp 6", cnt); end
        tests++; if ({bus_if.l1_resp_valid, bus_if.l1_resp_data, bus_if.l1_resp_shared, bus_if.l2_req_valid} !== {4'b0100, 64'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL wb_ack: got v%b d%h s%b l2v%b exp v0100 d0 s0 l2v0", bus_if.l1_resp_valid, bus_if.l1_resp_data,
                              bus_if.l1_resp_shared, bus_if.l2_req_valid); end
        step();
        #1;
        tests++; if (bus_if.l1_resp_valid !== 4'b0000) begin fails++; $display("FAIL wb_ack_pulse: got %b exp 0000", bus_if.l1_resp_valid); end
    endtask

    task automatic test_reset_midtxn();
        logic seen;
        step();
        set_req(3, RD, 26'h55, '0);
        #1;
        tests++; if (bus_if.l1_req_ready !== 4'b1000) begin fails++; $display("FAIL mid_grant: got %b exp 1000", bus_if.l1_req_ready); end
        step();
        bus_if.l1_req_valid[3] = 1'b0;
        step();
        step();
        bus_if.l2_req_ready = 1'b1;
        step();
        bus_if.l2_req_ready = 1'b0;
        #1;
        tests++; if ({bus_if.l1_snoop_addr, bus_if.l2_req_valid} !== {26'h55, 1'b0}) begin
            fails++; $display("FAIL mid_l2_wait: got a%h l2v%b exp a55 l2v0", bus_if.l1_snoop_addr, bus_if.l2_req_valid); end
        reset_n = 1'b0;
        #1;
        tests++; if ({bus_if.l1_snoop_addr, bus_if.l1_resp_valid, bus_if.l2_req_valid, bus_if.l1_snoop_valid} !== '0) begin
            fails++; $display("FAIL mid_async_reset: got a%h resp%b l2v%b sv%b exp 0", bus_if.l1_snoop_addr, bus_if.l1_resp_valid,
                              bus_if.l2_req_valid, bus_if.l1_snoop_valid); end
        step();
        reset_n = 1'b1;
        step();
        bus_if.l2_resp_valid = 1'b1;
        bus_if.l2_resp_data  = {8{8'hEE}};
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            bus_if.l2_resp_valid = 1'b0;
            #1;
            seen = seen | (|bus_if.l1_resp_valid);
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mid_no_resp: got %b exp 0", seen); end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_two_rd();
        test_rr_all();
        test_dirty();
        test_rdx();
        test_wb();
        test_reset_midtxn();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/coherence_bus_rr.md
Name: coherence_bus_rr

Overview:
Parametrised snooping coherence bus that connects NUM_CORES L1 controllers to a shared L2. It serialises one bus transaction at a time and uses a round-robin arbiter. Each transaction is broadcast as a snoop to every non-requesting L1. The line is supplied by cache-to-cache transfer when a peer holds it, otherwise it is fetched from L2. On a dirty intervention for BUS_RD, the bus also flushes the modified line to L2.

Parameters:
NUM_CORES, 4, number of L1 ports (>=2)
LINE_ADDR_BITS, `ADDR_BITS-`OFFSET_BITS, line-address width
LINE_BITS, `CACHELINE_BITS, cache line width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
l1_req_valid  in  NUM_CORES  per-core request valid
l1_req_ready  out  NUM_CORES  one-hot grant (accept) pulse
l1_req_addr  in  NUM_CORES*LINE_ADDR_BITS  packed per-core line address
l1_req  in  NUM_CORES x bus_req_t  per-core BUS_RD/BUS_RDX/BUS_UPGR/BUS_WB
l1_req_data  in  NUM_CORES*LINE_BITS  write-back data
l1_resp_valid  out  NUM_CORES  one-hot response pulse, to requester only
l1_resp_data  out  LINE_BITS  response line
l1_resp_shared  out  1  another core kept a copy (valid with l1_resp_valid)
l1_snoop_valid  out  NUM_CORES  snoop strobe, all except requester
l1_snoop_addr  out  LINE_ADDR_BITS  snooped line address
l1_snoop_req  out  bus_req_t  snooped request type
l1_snoop_shared  in  NUM_CORES  snooper holds line
l1_snoop_dirty  in  NUM_CORES  snooper holds line Modified (implies shared)
l1_snoop_data  in  NUM_CORES*LINE_BITS  snooper line data
l2_req_valid  out  1  L2 request valid
l2_req_ready  in  1  L2 accepts request
l2_req_addr  out  LINE_ADDR_BITS  L2 line address
l2_req_rw  out  1  0 read, 1 write
l2_req_data  out  LINE_BITS  L2 write data
l2_resp_valid  in  1  L2 read data valid
l2_resp_data  in  LINE_BITS  L2 read data

Behaviour:
- Clock and reset: one clock clk. reset_n is asynchronous and active-low.
- Reset values:
  - state=IDLE; rr_ptr=NUM_CORES-1 (core 0 wins first); req/addr/data/cpu registers=0.
  - All outputs are 0, including l1_resp_shared.
- Arbitration (IDLE):
  - Scan cores rr_ptr+1 .. rr_ptr+NUM_CORES, modulo NUM_CORES. The first core with valid set wins.
  - Same cycle: pulse l1_req_ready[winner]; latch type, address, data and cpu id; rr_ptr<=winner; go to SNOOP.
  - With no valid request, stay in IDLE and leave rr_ptr unchanged.
  - Valid and ready handshake in the same cycle. A requester must hold valid, addr and data stable until ready.
- SNOOP (1 cycle):
  - l1_snoop_valid = all ones except bit cpu. l1_snoop_addr and l1_snoop_req are driven from the latched registers in every state.
  - Transition by request type: BUS_UPGR -> DONE. BUS_WB -> L2_REQ with rw=1. BUS_RD/BUS_RDX -> SRESP.
- SRESP (1 cycle; snoop inputs sampled here):
  - shared_reg <= |l1_snoop_shared, masking the requester bit.
  - Data source is the lowest-index non-requester with dirty set; if none, the lowest with shared set. The chosen line is latched into data_reg.
  - Dirty source with BUS_RD -> FLUSH.
  - Any source with BUS_RDX, or a clean source with BUS_RD -> RESP.
  - No source -> L2_REQ with rw=0.
  - shared_reg is forced to 0 for BUS_RDX, because peers invalidate.
- FLUSH:
  - l2_req_valid=1, rw=1, data=data_reg. Held until l2_req_ready, then go to RESP.
  - The L2 write completes before the requester sees data.
- L2_REQ:
  - l2_req_valid=1. Hold until l2_req_ready.
  - When ready: rw=1 -> DONE; rw=0 -> L2_WAIT.
- L2_WAIT: wait for l2_resp_valid; then latch l2_resp_data into data_reg and go to RESP. Pulses outside L2_WAIT are ignored.
- RESP: l1_resp_valid[cpu]=1 for exactly 1 cycle. l1_resp_data=data_reg; l1_resp_shared=shared_reg. Then go to IDLE.
- DONE:
  - For BUS_UPGR and BUS_WB: l1_resp_valid[cpu]=1 for 1 cycle, as an acknowledgement, with data=0 and shared=0. Then go to IDLE.
  - Every request therefore gets exactly one response pulse.
- Latencies, grant cycle to response pulse:
  - UPGR 2 cycles.
  - Clean cache-to-cache RD/RDX 3 cycles.
  - Dirty RD 3 cycles + FLUSH wait (min 4).
  - L2 read 3 cycles + L2 ready wait + L2 response wait (min 5).
  - WB min 3.
- Outputs: l1_resp_* and l2_req_* are registered-state decodes, glitch-free.
- Next grant: occurs no earlier than the cycle after RESP/DONE, i.e. at most one transaction is in flight.
- Reset mid-transaction: the bus returns to IDLE immediately and abandons the transaction; no response pulse is issued afterwards.

Test Plan:
- Reset, then cores 0 and 2 request BUS_RD simultaneously with no sharers → core 0 is granted first and receives L2 data 0xA5..; core 2 is granted next; rr_ptr=2.
- Cores 0–3 all request continuously → grant order 0,1,2,3,0; each l1_req_ready is a one-cycle pulse.
- Core 1 BUS_RD at addr 0x40; core 3 asserts dirty with data 0xDEAD.. → L2 write of 0xDEAD.. to 0x40; after l2_req_ready, core 1 gets resp data 0xDEAD.. with shared=1 and no L2 read.
- Core 0 BUS_RDX; core 2 asserts shared, clean → resp data from core 2, shared=0, l2_req_valid never asserted.
- Core 2 BUS_WB with l2_req_ready held low 5 cycles → l2_req_valid with rw=1 held for 6 cycles, then a one-cycle ack on l1_resp_valid[2].
- reset_n asserted while in L2_WAIT → all outputs read 0 asynchronously; a later l2_resp_valid produces no l1_resp_valid.
